// File: rtl/cassette_rec_if.sv
// SDRAM tape-buffer write port shared by the recorder and the buffer controller.
// Carries address/data/request outward and the acknowledge back.
// The recorder drives the master side; the memory side answers on the slave side.
interface cassette_rec_if;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_dout;
  logic        sdram_wr;
  logic        sdram_ack;

  modport master (
    output sdram_addr,
    output sdram_dout,
    output sdram_wr,
    input  sdram_ack
  );

  modport slave (
    input  sdram_addr,
    input  sdram_dout,
    input  sdram_wr,
    output sdram_ack
  );
endinterface

// File: rtl/cassette_rec.sv
// Cassette recorder: decodes CoCo FSK cycles from din, locks on 0x55/0x3C, writes bytes to SDRAM.
// Latency: 2 clk sync + up to 1 en period per edge; byte completion to sdram_wr is 1 clk.
// Backpressure: one-deep write register held until ack; a byte completing while it is full is dropped and flagged.
module cassette_rec #(
  parameter int MIN_P        = 150,
  parameter int THRESH       = 560,
  parameter int MAX_P        = 1100,
  parameter int LEADER_BYTES = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic           record,
  input  logic           rewind,
  input  logic           din,
  cassette_rec_if.master sdram,
  output logic           overrun,
  output logic [2:0]     status
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HUNT   = 3'd1;
  localparam logic [2:0] S_LEADER = 3'd2;
  localparam logic [2:0] S_SYNC   = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;

  localparam logic [10:0] P_MIN     = 11'(MIN_P);
  localparam logic [10:0] P_THRESH  = 11'(THRESH);
  localparam logic [10:0] P_MAX     = 11'(MAX_P);
  localparam logic [10:0] P_SAT     = 11'(MAX_P + 1);
  localparam logic [7:0]  LEAD_LAST = 8'(LEADER_BYTES - 1);

  logic        din_s1_q, din_s2_q, din_prev_q, din_prev_d;
  logic        rec_prev_q, rec_prev_d, rew_prev_q, rew_prev_d;
  logic [10:0] cnt_q, cnt_d;
  logic [15:0] sr_q, sr_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  lcnt_q, lcnt_d;
  logic [2:0]  state_q, state_d;
  logic [24:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        wr_q, wr_d;
  logic        ack_pend_q, ack_pend_d;
  logic        ovr_q, ovr_d;

  logic        rise, rec_rise, rew_chg, bit_vld, bit_val, gap;
  logic        counting, byte_done, can_load, load;
  logic [15:0] sr_shift;
  logic [7:0]  load_dat;

  // Event decode for the current en tick: edges, bit classification, byte completion.
  always_comb begin
    rise      = en && din_s2_q && !din_prev_q;
    rec_rise  = en && record && !rec_prev_q;
    rew_chg   = en && (rewind != rew_prev_q);
    bit_vld   = rise && (cnt_q >= P_MIN) && (cnt_q <= P_MAX);
    bit_val   = (cnt_q < P_THRESH);
    gap       = en && (cnt_q == P_SAT);
    sr_shift  = {bit_val, sr_q[15:1]};
    counting  = (state_q == S_LEADER) || (state_q == S_SYNC) || (state_q == S_DATA);
    byte_done = bit_vld && counting && (bcnt_q == 3'd7);
    // A retiring write frees the holding register on the same edge a new byte lands.
    can_load  = !wr_q || ack_pend_q;
  end

  // Next-state logic: period counter, shift register, FSM and write port.
  always_comb begin
    din_prev_d = en ? din_s2_q : din_prev_q;
    rec_prev_d = en ? record : rec_prev_q;
    rew_prev_d = en ? rewind : rew_prev_q;
    cnt_d      = cnt_q;
    sr_d       = bit_vld ? sr_shift : sr_q;
    bcnt_d     = (bit_vld && counting) ? (bcnt_q + 3'd1) : bcnt_q;
    lcnt_d     = lcnt_q;
    state_d    = state_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    wr_d       = wr_q;
    ovr_d      = ovr_q;
    load       = 1'b0;
    load_dat   = 8'h00;
    // Ack is registered first; the request drops and the address moves one edge later.
    ack_pend_d = wr_q && sdram.sdram_ack && !ack_pend_q;

    if (en) begin
      if (rise && (cnt_q >= P_MIN)) begin
        cnt_d = 11'd1;
      end else if (cnt_q != P_SAT) begin
        cnt_d = cnt_q + 11'd1;
      end
    end

    if (ack_pend_q) begin
      wr_d   = 1'b0;
      addr_d = addr_q + 25'd1;
    end

    if (rew_chg) begin
      state_d    = S_IDLE;
      addr_d     = 25'd0;
      wr_d       = 1'b0;
      ack_pend_d = 1'b0;
      ovr_d      = 1'b0;
    end else if (rec_rise) begin
      if (state_q == S_IDLE) begin
        state_d = S_HUNT;
        sr_d    = 16'h0000;
      end else begin
        state_d = S_IDLE;
      end
    end else if (en) begin
      case (state_q)
        S_HUNT: begin
          if (bit_vld && (sr_shift == 16'h3C55)) begin
            bcnt_d  = 3'd0;
            lcnt_d  = 8'd0;
            state_d = S_LEADER;
          end
        end
        S_LEADER: begin
          if (can_load) begin
            load     = 1'b1;
            load_dat = 8'h55;
            lcnt_d   = lcnt_q + 8'd1;
            if (lcnt_q == LEAD_LAST) state_d = S_SYNC;
          end
        end
        S_SYNC: begin
          if (can_load) begin
            load     = 1'b1;
            load_dat = 8'h3C;
            state_d  = S_DATA;
          end
        end
        S_DATA: begin
          if (gap) begin
            state_d = S_HUNT;
            sr_d    = 16'h0000;
          end else if (byte_done) begin
            if (can_load) begin
              load     = 1'b1;
              load_dat = sr_shift[15:8];
            end else begin
              ovr_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
      // A byte finishing before the header has been written out cannot be stored.
      if (byte_done && (state_q != S_DATA)) ovr_d = 1'b1;
    end

    if (load) begin
      wr_d   = 1'b1;
      dout_d = load_dat;
    end
  end

  // State registers; din synchronizer runs every clk, the rest follows the next-state logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_s1_q   <= 1'b0;
      din_s2_q   <= 1'b0;
      din_prev_q <= 1'b0;
      rec_prev_q <= 1'b0;
      rew_prev_q <= 1'b0;
      cnt_q      <= 11'd0;
      sr_q       <= 16'h0000;
      bcnt_q     <= 3'd0;
      lcnt_q     <= 8'd0;
      state_q    <= S_IDLE;
      addr_q     <= 25'd0;
      dout_q     <= 8'h00;
      wr_q       <= 1'b0;
      ack_pend_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      din_s1_q   <= din;
      din_s2_q   <= din_s1_q;
      din_prev_q <= din_prev_d;
      rec_prev_q <= rec_prev_d;
      rew_prev_q <= rew_prev_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      bcnt_q     <= bcnt_d;
      lcnt_q     <= lcnt_d;
      state_q    <= state_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      wr_q       <= wr_d;
      ack_pend_q <= ack_pend_d;
      ovr_q      <= ovr_d;
    end
  end

  assign sdram.sdram_addr = addr_q;
  assign sdram.sdram_dout = dout_q;
  assign sdram.sdram_wr   = wr_q;
  assign overrun          = ovr_q;
  assign status           = state_q;

endmodule
